alu_wb_sequencer: RTL
=====================

Name: alu_wb_sequencer

Overview:
- Multi-cycle sequencer that sits around the 8x32 register file.
- Accepts one ALU instruction at a time through a valid/ready handshake and drives the register file read addresses.
- Consumes the QA/QB read data, computes the ALU result, then drives Di/Addr_W/WE to write the result back.
- Provides the operand-fetch and write-back control that the register file needs.

Parameters:
- none (width fixed at 32 data bits, 3-bit register addresses to match the 8x32 register file)

Ports:
- clk  input  1  system clock, rising edge
- cr  input  1  reset; synchronous, active-low
- instr_valid  input  1  instruction fields valid
- instr_ready  output  1  sequencer can accept an instruction
- op  input  3  ALU opcode
- ra  input  3  source register A
- rb  input  3  source register B
- rw  input  3  destination register
- QA  input  32  register file read port A data (combinational from Addr_A)
- QB  input  32  register file read port B data (combinational from Addr_B)
- Addr_A  output  3  register file read address A
- Addr_B  output  3  register file read address B
- Addr_W  output  3  register file write address
- Di  output  32  register file write data
- WE  output  1  register file write enable
- result  output  32  last computed result (registered)
- zero  output  1  result == 0
- overflow  output  1  signed overflow of last ADD/SUB, else 0
- done  output  1  one-cycle pulse in the WRITE cycle

Behaviour:
- Reset (cr=0 at a rising clk edge):
  - state=IDLE.
  - All registered outputs cleared: result, zero, overflow, done, WE, Addr_A, Addr_B, Addr_W = 0.
  - instr_ready=1 in the cycle after reset.
  - Reset mid-operation aborts the instruction; no write is issued (WE stays 0).
- States: IDLE -> READ -> EXEC -> WRITE -> IDLE. All transitions are unconditional except IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch op, ra, rb, rw and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Addr_A=ra and Addr_B=rb (registered, stable from this cycle).
  - QA/QB settle combinationally.
  - instr_ready=0.
- EXEC:
  - Sample QA/QB and compute the ALU result into result; update zero and overflow.
  - Addr_A/Addr_B stay held.
- WRITE:
  - WE=1, Addr_W=rw, Di=result, done=1 for exactly this cycle.
  - The register file commits at the clock edge ending WRITE.
- Latency:
  - Handshake edge = cycle 0; WE high in cycle 3.
  - One instruction per 4 cycles.
  - instr_valid is ignored outside IDLE, and fields may change freely then.
- WE, done: 0 in every state except WRITE. Di and Addr_W hold their last values when WE=0.
- ALU opcodes (32-bit, wrap-around arithmetic):
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 NOR
  - 101 SRL: QA >> QB[4:0], logical
  - 110 SUB: QA - QB
  - 111 SLT: 1 if signed QA < signed QB, else 0
- overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from QA.
  - All other opcodes: 0.
- Hazards:
  - ra/rb equal to the previous instruction's rw reads the newly written value, because the write commits before the next READ.
  - rw == ra or rw == rb is legal; the operands are the pre-write values.
- Simultaneous reset and instr_valid: reset wins, and the instruction is not accepted.

Test Plan:
- Reset, then hold instr_valid=0 for 10 cycles -> instr_ready=1, WE never 1, all outputs 0.
- Preload R1=5, R2=7 via the write path; issue ADD ra=1 rb=2 rw=3 -> WE=1 exactly 3 cycles after the handshake, Addr_W=3, Di=12, done pulses once, zero=0; R3 then reads 12.
- SUB ra=1 rb=1 rw=4 with R1=5 -> Di=0, zero=1; ADD with QA=0x7FFFFFFF, QB=1 -> Di=0x80000000, overflow=1; SLT with QA=0xFFFFFFFF, QB=0 -> Di=1.
- Back-to-back: ADD writes R3=12, next instruction XOR ra=3 rb=3 rw=5 -> XOR sees 12 and writes 0; instr_valid held high during READ/EXEC/WRITE is not re-accepted, giving exactly 2 writes.
- Assert cr=0 during EXEC of an instruction targeting R6 -> no WE pulse, R6 unchanged, state IDLE and instr_ready=1 after release.
- SRL with QA=0x80000000, QB=0x00000024 (shift 4) -> Di=0x08000000; NOR with QA=QB=0 -> Di=0xFFFFFFFF.

Source files
------------

// File: rtl/alu_wb_sequencer.sv
// Purpose : operand-fetch / ALU / write-back sequencer in front of an 8x32 register file.
// Latency : handshake edge = cycle 0, READ cycle 1, EXEC cycle 2, WE/done in cycle 3; one instruction per 4 cycles.
// Backpr. : instr_ready is high only in IDLE; instr_valid and the instruction fields are ignored elsewhere.
//
// Ports:
//   clk, cr                      clock (rising edge), synchronous active-low reset
//   instr_valid/instr_ready      instruction handshake; op/ra/rb/rw are the instruction fields
//   QA, QB                       register file read data (combinational from Addr_A/Addr_B)
//   Addr_A, Addr_B               register file read addresses (registered)
//   Addr_W, Di, WE               register file write port
//   result, zero, overflow       last ALU result and its flags (registered)
//   done                         one-cycle pulse in the WRITE cycle
module alu_wb_sequencer (
  input  logic        clk,
  input  logic        cr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  op,
  input  logic [2:0]  ra,
  input  logic [2:0]  rb,
  input  logic [2:0]  rw,
  input  logic [31:0] QA,
  input  logic [31:0] QB,
  output logic [2:0]  Addr_A,
  output logic [2:0]  Addr_B,
  output logic [2:0]  Addr_W,
  output logic [31:0] Di,
  output logic        WE,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op_q;
  logic [2:0]  rw_q;
  logic        accept;
  logic [31:0] alu_res;
  logic        alu_ovf;
  logic [31:0] sum;
  logic [31:0] diff;

  assign accept = instr_valid && instr_ready;

  // State register: reset wins over a simultaneous handshake.
  always_ff @(posedge clk) begin
    if (!cr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: only IDLE waits; the rest of the sequence is fixed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_READ;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode straight from the state register, so WE/done are glitch-free
  // and automatically low after reset or an aborted instruction.
  always_comb begin
    instr_ready = 1'b0;
    WE          = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE:  instr_ready = 1'b1;
      S_WRITE: begin
        WE   = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU: QA/QB have had the whole READ cycle to settle and are sampled at the
  // edge that ends EXEC.
  assign sum  = QA + QB;
  assign diff = QA - QB;

  always_comb begin
    alu_res = 32'd0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_AND: alu_res = QA & QB;
      OP_OR:  alu_res = QA | QB;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (QA[31] == QB[31]) && (sum[31] != QA[31]);
      end
      OP_XOR: alu_res = QA ^ QB;
      OP_NOR: alu_res = ~(QA | QB);
      OP_SRL: alu_res = QA >> QB[4:0];
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (QA[31] != QB[31]) && (diff[31] != QA[31]);
      end
      OP_SLT: alu_res = {31'd0, ($signed(QA) < $signed(QB))};
      default: ;
    endcase
  end

  // Datapath registers. Addr_A/Addr_B load at the handshake so they are already
  // valid in READ; Addr_W loads with the result so the whole write port changes
  // together and then holds while WE is low.
  always_ff @(posedge clk) begin
    if (!cr) begin
      op_q     <= 3'd0;
      rw_q     <= 3'd0;
      Addr_A   <= 3'd0;
      Addr_B   <= 3'd0;
      Addr_W   <= 3'd0;
      result   <= 32'd0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op;
        rw_q   <= rw;
        Addr_A <= ra;
        Addr_B <= rb;
      end
      if (state == S_EXEC) begin
        result   <= alu_res;
        zero     <= (alu_res == 32'd0);
        overflow <= alu_ovf;
        Addr_W   <= rw_q;
      end
    end
  end

  assign Di = result;

endmodule
